// File: rtl/mem_access_controller.sv
// Load/store initiator for the unified ROM/RAM memory: word-aligned bus access with sub-word
// extraction on loads, read-modify-write for sub-word stores, and rejection of illegal accesses.
module mem_access_controller #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ROM_BASE   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE   = 32'h1010_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  Write_Enable_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i
);

  typedef enum logic [2:0] {
    StIdle, StRdIssue, StRdCapt, StWr, StRmwIssue, StRmwCapt, StRmwWrite, StDone
  } state_e;

  state_e                  state_q;
  logic [1:0]              off_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    in_ram, in_rom, size_bad, req_err;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   merged;

  assign ready_o = (state_q == StIdle);

  // Everything below RAM_BASE, whether ROM or unmapped, is read-only.
  always_comb begin
    in_ram   = (addr_i >= RAM_BASE);
    in_rom   = (addr_i >= ROM_BASE) && !in_ram;
    size_bad = (size_i == 2'b11) ||
               ((size_i == 2'b01) && addr_i[0]) ||
               ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
    req_err  = size_bad || (we_i && (in_rom || !in_ram));
  end

  // Little-endian lane select/merge against the word returned by memory.
  always_comb begin
    byte_sel = Read_Data_i[{off_q, 3'b000} +: 8];
    half_sel = Read_Data_i[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{(DATA_WIDTH-8){~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{(DATA_WIDTH-16){~uns_q & half_sel[15]}}, half_sel};
      default: load_val = Read_Data_i;
    endcase
    merged = Read_Data_i;
    if (size_q == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      wdata_q        <= '0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      rdata_o        <= '0;
      Address_o      <= '0;
      Write_Data_o   <= '0;
      Write_Enable_o <= 1'b0;
    end else begin
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      Write_Enable_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            off_q     <= addr_i[1:0];
            size_q    <= size_i;
            uns_q     <= unsigned_i;
            wdata_q   <= wdata_i;
            Address_o <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            if (req_err) begin
              err_o   <= 1'b1;
              done_o  <= 1'b1;
              state_q <= StDone;
            end else if (!we_i) begin
              state_q <= StRdIssue;
            end else if (size_i == 2'b10) begin
              Write_Enable_o <= 1'b1;
              Write_Data_o   <= wdata_i;
              state_q        <= StWr;
            end else begin
              state_q <= StRmwIssue;
            end
          end
        end
        // Address is held one edge so the registered RAM output becomes valid.
        StRdIssue:  state_q <= StRdCapt;
        StRdCapt: begin
          rdata_o <= load_val;
          done_o  <= 1'b1;
          state_q <= StDone;
        end
        StWr: begin
          done_o  <= 1'b1;
          state_q <= StDone;
        end
        StRmwIssue: state_q <= StRmwCapt;
        StRmwCapt: begin
          Write_Data_o   <= merged;
          Write_Enable_o <= 1'b1;
          state_q        <= StRmwWrite;
        end
        StRmwWrite: begin
          done_o  <= 1'b1;
          state_q <= StDone;
        end
        StDone:     state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: ROM/RAM memory model plus a transaction-level reference
// model; directed cases followed by randomized loads/stores.
module tb_mem_access_controller;

  localparam logic [31:0] ROM_BASE = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE = 32'h1010_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        ready_o, done_o, err_o, Write_Enable_o;
  logic [31:0] rdata_o, Address_o, Write_Data_o, Read_Data_i;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_controller #(
    .DATA_WIDTH(32),
    .ROM_BASE  (ROM_BASE),
    .RAM_BASE  (RAM_BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req_i),
    .we_i          (we_i),
    .size_i        (size_i),
    .unsigned_i    (unsigned_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .rdata_o       (rdata_o),
    .Address_o     (Address_o),
    .Write_Data_o  (Write_Data_o),
    .Write_Enable_o(Write_Enable_o),
    .Read_Data_i   (Read_Data_i)
  );

  always #5 clk = ~clk;

  // Memory: combinational ROM, registered-output RAM, 256 words each.
  logic [31:0] rom     [256];
  logic [31:0] ram     [256];
  logic [31:0] ref_ram [256];
  logic [31:0] ram_rd_q;
  bit          mem_loaded = 1'b0;

  function automatic int widx(input logic [31:0] a, input logic [31:0] base);
    return int'(((a - base) >> 2) & 32'hFF);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h80FF_7F01;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      ram_rd_q <= ram[widx(Address_o, RAM_BASE)];
      if (Write_Enable_o && (Address_o >= RAM_BASE))
        ram[widx(Address_o, RAM_BASE)] <= Write_Data_o;
    end
  end

  always_comb begin
    Read_Data_i = (Address_o >= RAM_BASE) ? ram_rd_q : rom[widx(Address_o, ROM_BASE)];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] last_wdat;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= RAM_BASE) return ref_ram[widx(a, RAM_BASE)];
    return rom[widx(a, ROM_BASE)];
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 10 && !ready_o; i++) begin
      @(posedge clk); #1;
    end
    check("ready_idle", ready_o, 1'b1);
  endtask

  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    bit          e;
    int          lat, sh, done_cyc, we_cnt, we_cyc;
    logic [31:0] word, mask, lmask, expv, newv, wdat;
    logic        err_seen;
    sh    = int'(a[1:0]) * 8;
    mask  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    e     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
            (we && a < RAM_BASE);
    lat   = e ? 1 : !we ? 3 : (sz == 2'd2) ? 2 : 4;
    word  = model_read(a);
    newv  = word;
    if (!e && !we) begin
      expv = (word >> sh) & mask;
      if (!uns && ((expv & ((mask >> 1) + 32'd1)) != 0)) expv = expv | ~mask;
      exp_rdata = expv;
    end
    if (!e && we) begin
      lmask = mask << sh;
      newv  = (word & ~lmask) | ((wd << sh) & lmask);
      ref_ram[widx(a, RAM_BASE)] = newv;
    end

    wait_ready();
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0; wdata_i = $urandom; addr_i = $urandom;
    done_cyc = 0; we_cnt = 0; we_cyc = 0; wdat = 32'h0; err_seen = 1'b0;
    for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
      if (c == 1) begin
        check("addr_out", Address_o, a & ~32'h3);
        check("busy", ready_o, 1'b0);
      end
      if (Write_Enable_o) begin we_cnt++; we_cyc = c; wdat = Write_Data_o; end
      if (done_o) begin done_cyc = c; err_seen = err_o; end
      @(posedge clk); #1;
    end
    last_wdat = wdat;
    check("done_latency", done_cyc, lat);
    check("err", err_seen, e);
    check("we_pulses", we_cnt, (!e && we) ? 1 : 0);
    if (!e && we) begin
      check("we_cycle", we_cyc, lat - 1);
      check("write_data", wdat, newv);
    end
    check("rdata", rdata_o, exp_rdata);
    check("done_single", done_o, 1'b0);
  endtask

  // Start an access and pull reset partway through it.
  task automatic abort_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int abort_cyc);
    int we_cnt, done_cnt;
    wait_ready();
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = 1'b0; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int c = 1; c < abort_cyc; c++) begin
      @(posedge clk); #1;
    end
    if (we && sz == 2'd2) check("we_before_abort", Write_Enable_o, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_ready", ready_o, 1'b1);
    check("abort_we", Write_Enable_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_rdata", rdata_o, 32'h0);
    check("abort_addr", Address_o, 32'h0);
    exp_rdata = 32'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    we_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (Write_Enable_o) we_cnt++;
      if (done_o) done_cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_we", we_cnt, 0);
    check("abort_no_done", done_cnt, 0);
  endtask

  initial begin
    logic        r_we, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    for (int i = 0; i < 256; i++) begin
      rom[i]     = $urandom;
      ref_ram[i] = init_word(i);
    end
    rom[1] = 32'h2008_0005;
    reset = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 1'b1);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_we", Write_Enable_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_addr", Address_o, 32'h0);
    check("rst_wdata", Write_Data_o, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 2'd2, 1'b0, 32'h0040_0004, 32'h0);
    check("tp_rom_word", rdata_o, 32'h2008_0005);
    run_op(1'b0, 2'd0, 1'b0, 32'h1010_0003, 32'h0);
    check("tp_byte_signed", rdata_o, 32'hFFFF_FF80);
    run_op(1'b0, 2'd0, 1'b1, 32'h1010_0003, 32'h0);
    check("tp_byte_unsigned", rdata_o, 32'h0000_0080);
    run_op(1'b0, 2'd1, 1'b0, 32'h1010_0000, 32'h0);
    check("tp_half_signed", rdata_o, 32'h0000_7F01);

    run_op(1'b1, 2'd2, 1'b0, 32'h1010_0000, 32'h1122_3344);
    run_op(1'b1, 2'd0, 1'b0, 32'h1010_0001, 32'hFFFF_FFAB);
    check("tp_rmw_data", last_wdat, 32'h1122_AB44);
    run_op(1'b0, 2'd2, 1'b0, 32'h1010_0000, 32'h0);
    check("tp_rmw_readback", rdata_o, 32'h1122_AB44);
    run_op(1'b1, 2'd2, 1'b0, 32'h1010_0008, 32'hDEAD_BEEF);
    run_op(1'b0, 2'd2, 1'b0, 32'h1010_0008, 32'h0);
    check("tp_word_readback", rdata_o, 32'hDEAD_BEEF);

    run_op(1'b0, 2'd2, 1'b0, 32'h1010_0002, 32'h0);
    run_op(1'b1, 2'd2, 1'b0, 32'h0040_0000, 32'h1234_5678);
    run_op(1'b0, 2'd3, 1'b0, 32'h1010_0004, 32'h0);
    check("tp_err_hold", rdata_o, 32'hDEAD_BEEF);

    abort_op(1'b1, 2'd1, 32'h1010_0002, 32'h0000_5566, 2);
    run_op(1'b0, 2'd2, 1'b0, 32'h1010_0000, 32'h0);
    check("tp_abort_readback", rdata_o, 32'h1122_AB44);
    abort_op(1'b1, 2'd2, 32'h1010_000C, 32'hCAFE_F00D, 1);
    run_op(1'b0, 2'd2, 1'b0, 32'h1010_000C, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      r_sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_a   = (($urandom_range(0, 3) == 0) ? ROM_BASE : RAM_BASE) + 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'd1) r_a[0] = 1'b0;
        if (r_sz == 2'd2) r_a[1:0] = 2'b00;
      end
      run_op(r_we, r_sz, r_uns, r_a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Initiator for the unified ROM/RAM memory system; it sits between the multicycle control unit/datapath and the memory.
- Accepts load/store requests of byte, halfword or word size through a req/ready/done handshake.
- Drives a word-aligned address, write data and write enable, and captures read data at a fixed latency.
- Performs sign/zero extension for sub-word loads and read-modify-write for sub-word stores; flags misaligned accesses and stores to ROM.

Parameters:
- DATA_WIDTH, 32, data/address width.
- ROM_BASE, 32'h00400000, text (ROM) region base.
- RAM_BASE, 32'h10100000, data (RAM) region base; an address >= RAM_BASE is RAM, otherwise ROM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  1  request strobe; sampled only when ready_o=1.
- we_i  in  1  1=store, 0=load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- unsigned_i  in  1  load zero-extend (1) / sign-extend (0).
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- ready_o  out  1  idle, can accept a request.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o; access rejected.
- rdata_o  out  32  extended load result.
- Address_o  out  32  word-aligned address to memory.
- Write_Data_o  out  32  word to memory.
- Write_Enable_o  out  1  memory write strobe.
- Read_Data_i  in  32  memory read word; RAM output is registered, ROM output is combinational.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; ready_o=1.
  - done_o, err_o, Write_Enable_o = 0.
  - rdata_o, Address_o, Write_Data_o = 0.
- States: IDLE, RD_ISSUE, RD_CAPT, WR, RMW_ISSUE, RMW_CAPT, RMW_WRITE, DONE.
- IDLE (ready_o=1):
  - On req_i, latch addr, wdata, size, we and unsigned; set Address_o={addr[31:2],2'b00}.
  - Reject with err_o=1 (go to DONE, no memory write) if size=11, half with addr[0]=1, word with addr[1:0]!=0, or store with addr<RAM_BASE.
  - Otherwise: load -> RD_ISSUE; word store -> WR; byte/half store -> RMW_ISSUE.
- RD_ISSUE: hold Address_o across one rising edge so the RAM registers its output -> RD_CAPT.
- RD_CAPT:
  - Select the lane from Read_Data_i using little-endian order: byte n = bits [8n+7:8n]; half at addr[1]=1 is [31:16].
  - Extend per unsigned_i and register into rdata_o -> DONE.
- WR: Write_Enable_o=1 for exactly this cycle; Write_Data_o=wdata -> DONE.
- RMW_ISSUE: same as RD_ISSUE -> RMW_CAPT.
- RMW_CAPT: merged = Read_Data_i with the target lane replaced by wdata[7:0] or wdata[15:0] -> RMW_WRITE.
- RMW_WRITE: Write_Enable_o=1 for one cycle; Write_Data_o=merged -> DONE.
- DONE: done_o=1 for one cycle (err_o accompanies it only when rejected) -> IDLE.
- Output hold rules:
  - rdata_o holds until the next accepted load; stores and errors do not change it.
  - Address_o holds its last value in IDLE.
- Latency, counting the acceptance edge as cycle 0, done_o is high in:
  - error: cycle 1
  - word store: cycle 2
  - load: cycle 3
  - sub-word store: cycle 4
- ready_o=0 outside IDLE; req_i is ignored there. A request can be accepted in the cycle after DONE.
- Write_Enable_o is high only in WR/RMW_WRITE: never two consecutive cycles, never on a rejected access.
- Reset mid-operation: immediate return to IDLE; Write_Enable_o drops asynchronously; a pending write is abandoned with no done_o.
- Address arithmetic is unsigned 32-bit; no wrap checking beyond the region compare.

Test Plan:
- Word load from ROM 0x00400004 (content 0x20080005) -> Address_o=0x00400004, done_o in cycle 3, rdata_o=0x20080005, err_o=0, Write_Enable_o never high.
- Byte loads from RAM 0x10100003 (word 0x80FF7F01):
  - signed -> rdata_o=0xFFFFFF80.
  - unsigned -> rdata_o=0x00000080.
  - signed half at 0x10100000 -> 0x00007F01.
- Byte store 0xAB to 0x10100001 (word 0x11223344) -> single Write_Enable_o pulse in cycle 3 with Write_Data_o=0x1122AB44, done_o in cycle 4; a read-back returns 0x1122AB44.
- Word store 0xDEADBEEF to 0x10100008 -> Write_Enable_o in cycle 1 only, done_o in cycle 2; a subsequent load returns 0xDEADBEEF.
- Rejected accesses:
  - word load at 0x10100002 -> done_o and err_o in cycle 1.
  - store to 0x00400000 -> same.
  - size_i=11 -> same.
  - In all cases Write_Enable_o stays 0 and rdata_o is unchanged.
- Reset pulled low during RMW_CAPT of a half store -> no Write_Enable_o and no done_o; ready_o=1 immediately; a new word load afterwards completes normally in 3 cycles.
